sram_port_master: RTL

- Initiator for one RW port of the OpenRAM dual-port macro (8-bit x 64-word), used to feed the systolic array.
- Accepts single-word write requests and burst-read commands.
- Drives the macro's csb/web/addr/din pins and returns read data as a valid/ready stream.
- A 2-entry output buffer with credit-based issue absorbs the macro's 1-cycle read latency under backpressure, with no data loss and full throughput.

---
 rtl/sram_port_master_if.sv | 55 +++++
 rtl/sram_port_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sram_port_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_master_if
//  Purpose  : Bundles the write-request, burst-command and read-stream
//             handshakes plus the OpenRAM RW-port pins of sram_port_master.
//             The master modport is the initiator's view; the slave modport is
//             the view of the environment (requester, consumer and macro).
//  Revision : 1.0  initial release
// ============================================================================
interface sram_port_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 7
);
  // Single-word write requests
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  // Burst-read commands
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  // Read data stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  // Status
  logic                  busy;
  logic                  done;
  // Macro RW port pins
  logic                  sram_csb;
  logic                  sram_web;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport master (
    input  wr_valid, wr_addr, wr_data,
    input  cmd_valid, cmd_addr, cmd_len,
    input  out_ready, sram_dout,
    output wr_ready, cmd_ready, out_valid, out_data, busy, done,
    output sram_csb, sram_web, sram_addr, sram_din
  );

  modport slave (
    output wr_valid, wr_addr, wr_data,
    output cmd_valid, cmd_addr, cmd_len,
    output out_ready, sram_dout,
    input  wr_ready, cmd_ready, out_valid, out_data, busy, done,
    input  sram_csb, sram_web, sram_addr, sram_din
  );
endinterface
`default_nettype wire

// File: rtl/sram_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_master
//  Purpose  : Initiator for one RW port of an OpenRAM macro. Performs single
//             word writes and burst reads; read data leaves through a 2-entry
//             buffer whose credit check absorbs the macro's 1-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module sram_port_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 7
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic                  pop;
  logic                  issue;
  logic                  cap_slot1;
  logic [2:0]            credit_used;

  // Buffer head is always buf0; a pop this cycle frees its slot for an issue.
  assign pop         = (cnt_q != 2'd0) && bus.out_ready;
  assign credit_used = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  // Captured word lands behind whatever survives this cycle's pop.
  assign cap_slot1   = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
  assign cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = buf0_q;
  assign bus.busy      = (state_q != S_IDLE);

  // Next-state, macro pin drive and handshake readiness.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    din_d         = din_q;
    issue         = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.done      = 1'b0;
    bus.sram_csb  = 1'b1;
    bus.sram_web  = 1'b1;
    bus.sram_addr = addr_q;
    bus.sram_din  = din_q;
    case (state_q)
      S_IDLE: begin
        // Readiness is withheld while reset is asserted so the pins stay quiet.
        bus.wr_ready  = !rst;
        bus.cmd_ready = !rst && !bus.wr_valid;
        if (!rst && bus.wr_valid) begin
          bus.sram_csb  = 1'b0;
          bus.sram_web  = 1'b0;
          bus.sram_addr = bus.wr_addr;
          bus.sram_din  = bus.wr_data;
          din_d         = bus.wr_data;
        end else if (!rst && bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = (bus.cmd_len == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        issue = (rem_q != '0) && (credit_used < 3'd2);
        if (issue) begin
          bus.sram_csb = 1'b0;
          addr_d       = addr_q + ADDR_WIDTH'(1);
          rem_d        = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (cnt_q == 2'd0)) begin
          bus.done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    inflight_d = issue;
  end

  // FSM state, counters and last-written data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      din_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      din_q      <= din_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  // Two-entry output buffer: shift on pop, then capture the macro output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      if (pop) begin
        buf0_q <= buf1_q;
      end
      if (inflight_q) begin
        if (cap_slot1) begin
          buf1_q <= bus.sram_dout;
        end else begin
          buf0_q <= bus.sram_dout;
        end
      end
    end
  end

endmodule
`default_nettype wire
